// File: rtl/threshold_trigger_framer_pkg.sv
// Shared definitions for the threshold trigger framer: word tags, field
// positions, FSM encodings and word-building helpers.
package krd_trig_pkg;

    localparam int TS_WIDTH    = 30;
    localparam int COUNT_WIDTH = 16;
    localparam int WORD_WIDTH  = 32;

    localparam logic [1:0] HDR = 2'b10;
    localparam logic [1:0] DAT = 2'b00;
    localparam logic [1:0] FTR = 2'b11;

    localparam int TAG_MSB       = 31;
    localparam int TAG_LSB       = 30;
    localparam int FTR_TRUNC_BIT = 29;
    localparam int DATA_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        SKIP = 2'd2
    } frm_state_e;

    function automatic logic [WORD_WIDTH-1:0] hdr_word(input logic [TS_WIDTH-1:0] ts);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[TAG_MSB:TAG_LSB] = HDR;
        w[TS_WIDTH-1:0]    = ts;
        return w;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] dat_word(input logic [DATA_WIDTH-1:0] sample);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[TAG_MSB:TAG_LSB]  = DAT;
        w[DATA_WIDTH-1:0]   = sample;
        return w;
    endfunction

    function automatic logic [WORD_WIDTH-1:0] ftr_word(input logic trunc,
                                                       input logic [COUNT_WIDTH-1:0] cnt);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[TAG_MSB:TAG_LSB] = FTR;
        w[FTR_TRUNC_BIT]   = trunc;
        w[COUNT_WIDTH-1:0] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/threshold_trigger_framer_if.sv
// ADC sample stream in, FIFO write side out. The framer is the master.
interface threshold_trigger_framer_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] ADC_DATA;
    logic                    ADC_VALID;
    logic [31:0]             FIFO_DIN;
    logic                    FIFO_WE;
    logic                    FIFO_ALMOST_FULL;
    logic                    FIFO_FULL;

    modport master (
        input  ADC_DATA,
        input  ADC_VALID,
        input  FIFO_ALMOST_FULL,
        input  FIFO_FULL,
        output FIFO_DIN,
        output FIFO_WE
    );

    modport slave (
        output ADC_DATA,
        output ADC_VALID,
        output FIFO_ALMOST_FULL,
        output FIFO_FULL,
        input  FIFO_DIN,
        input  FIFO_WE
    );
endinterface

// File: rtl/threshold_trigger_framer_pretrigger_delay_line.sv
// Shift register holding the pre-trigger history; advances only on shift_en
// and clears synchronously.
module pretrigger_delay_line #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 17
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge CLK) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (shift_en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/threshold_trigger_framer.sv
// Frames above-threshold regions of an ADC stream (header, pre, hit, post,
// footer) into the threshold FIFO, dropping whole frames under backpressure.
//
// state | meaning
// IDLE  | waiting for a trigger on the input side
// BODY  | emitting delayed samples of the current frame into the FIFO
// SKIP  | discarding the rest of a dropped or truncated frame until its end tag
module threshold_trigger_framer
    import krd_trig_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PRE_SAMPLES  = 4,
    parameter int POST_SAMPLES = 4,
    parameter int MAX_SAMPLES  = 256
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    threshold_trigger_framer_if.master    bus,
    input  logic [SAMPLE_WIDTH-1:0]       THRESHOLD,
    output logic [COUNT_WIDTH-1:0]        LOST_COUNT,
    output logic                          OVERFLOW,
    output logic                          BUSY
);

    localparam int DL_DEPTH = PRE_SAMPLES + 1;
    localparam int DL_WIDTH = SAMPLE_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] POST_RELOAD = COUNT_WIDTH'(POST_SAMPLES);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT   = COUNT_WIDTH'(MAX_SAMPLES);
    localparam logic [COUNT_WIDTH-1:0] LOST_SAT    = '1;

    logic [SAMPLE_WIDTH-1:0] sample;
    logic                    valid;
    logic                    hit;
    logic                    w;
    logic                    trigger;
    logic                    end_tag;
    logic [COUNT_WIDTH-1:0]  post_cnt;
    logic                    in_frame_in;
    logic [TS_WIDTH-1:0]     ts;

    logic [DL_WIDTH-1:0]     dl_din;
    logic [DL_WIDTH-1:0]     dl_dout;
    logic                    dly_end;
    logic [SAMPLE_WIDTH-1:0] dly_sample;

    frm_state_e              state_q;
    frm_state_e              state_d;
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [COUNT_WIDTH-1:0]  count_d;
    logic                    wr_d;
    logic [WORD_WIDTH-1:0]   word_d;
    logic                    lost_inc;

    assign sample = bus.ADC_DATA;
    assign valid  = bus.ADC_VALID;

    // Input side: w covers the hit itself plus the post-trigger tail.
    assign hit     = sample > THRESHOLD;
    assign w       = hit || (post_cnt != '0);
    assign trigger = w && (state_q == IDLE) && !in_frame_in;
    assign end_tag = in_frame_in && !w;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            post_cnt    <= '0;
            in_frame_in <= 1'b0;
        end else if (valid) begin
            if (hit) begin
                post_cnt <= POST_RELOAD;
            end else if (post_cnt != '0) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (trigger) begin
                in_frame_in <= 1'b1;
            end else if (end_tag) begin
                in_frame_in <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign dl_din = {end_tag, sample};

    pretrigger_delay_line #(
        .DEPTH (DL_DEPTH),
        .WIDTH (DL_WIDTH)
    ) u_delay (
        .CLK      (CLK),
        .clr      (!RESETN),
        .shift_en (valid),
        .din      (dl_din),
        .dout     (dl_dout)
    );

    assign dly_end    = dl_dout[DL_WIDTH-1];
    assign dly_sample = dl_dout[SAMPLE_WIDTH-1:0];

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The header takes the slot of the delayed sample leaving the line on the
    // trigger cycle, so the frame starts exactly PRE_SAMPLES samples early.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_d     = 1'b0;
        word_d   = '0;
        lost_inc = 1'b0;
        if (valid) begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        if (!bus.FIFO_ALMOST_FULL) begin
                            wr_d    = 1'b1;
                            word_d  = hdr_word(ts);
                            count_d = '0;
                            state_d = BODY;
                        end else begin
                            lost_inc = 1'b1;
                            state_d  = SKIP;
                        end
                    end
                end
                BODY: begin
                    if (dly_end) begin
                        wr_d    = 1'b1;
                        word_d  = ftr_word(1'b0, count_q);
                        state_d = IDLE;
                    end else if (count_q == MAX_COUNT) begin
                        wr_d    = 1'b1;
                        word_d  = ftr_word(1'b1, count_q);
                        state_d = SKIP;
                    end else begin
                        wr_d    = 1'b1;
                        word_d  = dat_word(DATA_WIDTH'(dly_sample));
                        count_d = count_q + 1'b1;
                    end
                end
                SKIP: begin
                    if (dly_end) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A mid-frame reset leaves the FIFO with a footer-less frame; the FIFO
    // is reset by the same RESETN so nothing downstream sees it.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            bus.FIFO_WE  <= 1'b0;
            bus.FIFO_DIN <= '0;
            LOST_COUNT   <= '0;
            OVERFLOW     <= 1'b0;
        end else begin
            bus.FIFO_WE  <= wr_d;
            bus.FIFO_DIN <= word_d;
            if (lost_inc && (LOST_COUNT != LOST_SAT)) begin
                LOST_COUNT <= LOST_COUNT + 1'b1;
            end
            if (bus.FIFO_WE && bus.FIFO_FULL) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_threshold_trigger_framer.sv
// Directed bench for threshold_trigger_framer: captures every FIFO write and
// compares the word stream against hand-derived frames.
module tb_threshold_trigger_framer;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [15:0] THRESHOLD = 16'd100;
    logic [15:0] LOST_COUNT;
    logic        OVERFLOW;
    logic        BUSY;

    threshold_trigger_framer_if #(.SAMPLE_WIDTH(16)) bus ();

    threshold_trigger_framer #(
        .SAMPLE_WIDTH (16),
        .PRE_SAMPLES  (4),
        .POST_SAMPLES (4),
        .MAX_SAMPLES  (256)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .bus        (bus),
        .THRESHOLD  (THRESHOLD),
        .LOST_COUNT (LOST_COUNT),
        .OVERFLOW   (OVERFLOW),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad = 0;
    int          we_bad = 0;
    logic        prev_v = 1'b0;
    logic [29:0] ts_m;
    logic [15:0] samp [512];
    bit          af_a [512];
    bit          full_a [512];
    logic [29:0] ts_at [512];
    logic [31:0] wr_q [$];
    logic [31:0] exp_q [$];

    always @(posedge CLK) begin
        if (!RESETN) ts_m <= '0;
        else         ts_m <= ts_m + 1'b1;
        prev_v <= bus.ADC_VALID;
    end

    always @(negedge CLK) begin
        if (bus.FIFO_WE === 1'b1) begin
            wr_q.push_back(bus.FIFO_DIN);
            if (!prev_v) we_bad++;
        end
    end

    task automatic bg_fill();
        for (int i = 0; i < 512; i++) begin
            samp[i]   = 16'd50;
            af_a[i]   = 1'b0;
            full_a[i] = 1'b0;
            ts_at[i]  = '0;
        end
    endtask

    task automatic send(input int i);
        @(negedge CLK);
        bus.ADC_DATA         = samp[i];
        bus.ADC_VALID        = 1'b1;
        bus.FIFO_ALMOST_FULL = af_a[i];
        bus.FIFO_FULL        = full_a[i];
        ts_at[i]             = ts_m;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        bus.ADC_DATA         = '0;
        bus.ADC_VALID        = 1'b0;
        bus.FIFO_ALMOST_FULL = 1'b0;
        bus.FIFO_FULL        = 1'b0;
    endtask

    task automatic stream(input int from, input int to, input bit toggle);
        for (int i = from; i <= to; i++) begin
            send(i);
            if (toggle) idle_cycle();
        end
    endtask

    task automatic flush();
        idle_cycle();
        idle_cycle();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESETN               = 1'b0;
        bus.ADC_VALID        = 1'b0;
        bus.ADC_DATA         = '0;
        bus.FIFO_ALMOST_FULL = 1'b0;
        bus.FIFO_FULL        = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        wr_q.delete();
        exp_q.delete();
        we_bad = 0;
    endtask

    // Expected frame: header, samples first..last as data words, footer.
    task automatic push_frame(input logic [29:0] ts, input int first, input int last,
                              input bit trunc);
        exp_q.push_back({2'b10, ts});
        for (int i = first; i <= last; i++) exp_q.push_back({16'h0000, samp[i]});
        exp_q.push_back({2'b11, trunc, 13'b0, 16'(last - first + 1)});
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (bus.FIFO_WE !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.FIFO_WE); end
        total++; if (bus.FIFO_DIN !== 32'h0) begin bad++; $display("FAIL rst_din: got %h want 0", bus.FIFO_DIN); end
        total++; if (LOST_COUNT !== 16'h0) begin bad++; $display("FAIL rst_lost: got %0d want 0", LOST_COUNT); end
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", OVERFLOW); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        RESETN = 1'b1;
    endtask

    task automatic test_single_pulse();
        logic [31:0] got;
        bg_fill();
        samp[10] = 16'd200; samp[11] = 16'd200;
        apply_reset();
        stream(0, 29, 1'b0);
        flush();
        push_frame(ts_at[10], 6, 15, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL single_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL single_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (LOST_COUNT !== 16'd0) begin bad++; $display("FAIL single_lost: got %0d want 0", LOST_COUNT); end
        total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", OVERFLOW); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_valid_gaps();
        logic [31:0] got;
        bg_fill();
        samp[10] = 16'd200; samp[11] = 16'd200;
        apply_reset();
        stream(0, 29, 1'b1);
        flush();
        push_frame(ts_at[10], 6, 15, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL gaps_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL gaps_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (we_bad != 0) begin bad++; $display("FAIL gaps_we_after_invalid: got %0d writes want 0", we_bad); end
    endtask

    task automatic test_almost_full_drop();
        logic [31:0] got;
        bg_fill();
        samp[10] = 16'd200; samp[11] = 16'd200;
        af_a[10] = 1'b1;    af_a[11] = 1'b1;
        samp[40] = 16'd200;
        apply_reset();
        stream(0, 9, 1'b0);
        total++; if (LOST_COUNT !== 16'd0) begin bad++; $display("FAIL af_lost_before: got %0d want 0", LOST_COUNT); end
        stream(10, 30, 1'b0);
        total++; if (wr_q.size() != 0) begin bad++; $display("FAIL af_dropped_nwr: got %0d want 0", wr_q.size()); end
        total++; if (LOST_COUNT !== 16'd1) begin bad++; $display("FAIL af_lost_after: got %0d want 1", LOST_COUNT); end
        stream(31, 59, 1'b0);
        flush();
        push_frame(ts_at[40], 36, 44, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL af_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL af_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (LOST_COUNT !== 16'd1) begin bad++; $display("FAIL af_lost_final: got %0d want 1", LOST_COUNT); end
    endtask

    // Second hit extends the tail; mid-frame AF is ignored and FULL flags overflow.
    task automatic test_retrigger_extend();
        logic [31:0] got;
        bg_fill();
        samp[10] = 16'd200; samp[13] = 16'd200;
        af_a[12] = 1'b1; af_a[13] = 1'b1;
        full_a[12] = 1'b1;
        apply_reset();
        stream(0, 29, 1'b0);
        flush();
        push_frame(ts_at[10], 6, 17, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL ext_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL ext_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ext_ovf: got %b want 1", OVERFLOW); end
        total++; if (LOST_COUNT !== 16'd0) begin bad++; $display("FAIL ext_lost: got %0d want 0", LOST_COUNT); end
    endtask

    task automatic test_truncation();
        logic [31:0] got;
        bg_fill();
        for (int i = 10; i <= 309; i++) samp[i] = 16'd200;
        samp[360] = 16'd200;
        apply_reset();
        stream(0, 290, 1'b0);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL trunc_busy_skip: got %b want 1", BUSY); end
        stream(291, 379, 1'b0);
        flush();
        push_frame(ts_at[10], 6, 261, 1'b1);
        push_frame(ts_at[360], 356, 364, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL trunc_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL trunc_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL trunc_busy_end: got %b want 0", BUSY); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got;
        bg_fill();
        samp[10] = 16'd200; samp[11] = 16'd200;
        apply_reset();
        stream(0, 14, 1'b0);
        idle_cycle();
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", BUSY); end
        apply_reset();
        total++; if (bus.FIFO_WE !== 1'b0) begin bad++; $display("FAIL mid_we: got %b want 0", bus.FIFO_WE); end
        total++; if (bus.FIFO_DIN !== 32'h0) begin bad++; $display("FAIL mid_din: got %h want 0", bus.FIFO_DIN); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", BUSY); end
        stream(0, 29, 1'b0);
        flush();
        // One idle cycle follows reset release, so sample j carries ts j+1.
        push_frame(30'd11, 6, 15, 1'b0);
        total++; if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_nwr: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_q[i]) begin bad++; $display("FAIL mid_word[%0d]: got %h want %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        bus.ADC_DATA         = '0;
        bus.ADC_VALID        = 1'b0;
        bus.FIFO_ALMOST_FULL = 1'b0;
        bus.FIFO_FULL        = 1'b0;
        test_reset();
        test_single_pulse();
        test_valid_gaps();
        test_almost_full_drop();
        test_retrigger_extend();
        test_truncation();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
